serial_compare_sequencer: RTL and testbench

Sequences one serial magnitude comparison for the bit-serial `serial_comparator` stage. It accepts two WIDTH-bit operands over a valid/ready handshake and clears the comparator. It then shifts both operands into the comparator MSB-first, one bit per clock. Finally it captures the comparator's sticky greater/equal/less flags and presents them as a registered result over a second valid/ready handshake. The block sits directly upstream of the comparator, driving its `a`, `b` and `reset` inputs, and also consumes its `g`, `e` and `l` outputs.

---
 rtl/serial_cmp_pkg.sv | 21 ++
 rtl/serial_compare_sequencer_if.sv | 27 ++
 rtl/piso_shift_reg.sv | 30 +++
 rtl/serial_comparator.sv | 29 ++
 rtl/serial_compare_sequencer.sv | 124 ++++++++++++
 tb/tb_serial_compare_sequencer.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial compare sequencer.
// Flag order is {g,e,l} wherever the three comparator flags travel together.
package serial_cmp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic logic is_one_hot3(input logic [2:0] flags);
        return (flags == RES_GT) || (flags == RES_EQ) || (flags == RES_LT);
    endfunction

endpackage

// File: rtl/serial_compare_sequencer_if.sv
// Operand and result handshakes of the serial compare sequencer.
// The master modport is the producer/consumer side; the sequencer uses slave.
interface serial_compare_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic             res_gt;
    logic             res_eq;
    logic             res_lt;
    logic             res_err;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, res_gt, res_eq, res_lt, res_err
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, res_gt, res_eq, res_lt, res_err
    );

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register; MSB leaves first, zeros fill from the LSB.
// Load takes priority over shift.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] r_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= par_in;
        end else if (shift) begin
            r_data <= r_data << 1;
        end
    end

    assign ser_out = r_data[WIDTH-1];

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator with sticky g/e/l flags.
// The first differing bit decides; synchronous active-high reset returns to "equal".
module serial_comparator (
    input  logic clock,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic g,
    output logic e,
    output logic l
);

    always_ff @(posedge clock) begin
        if (reset) begin
            g <= 1'b0;
            e <= 1'b1;
            l <= 1'b0;
        end else if (e) begin
            if (a && !b) begin
                g <= 1'b1;
                e <= 1'b0;
            end else if (!a && b) begin
                l <= 1'b1;
                e <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_compare_sequencer.sv
// Accepts an operand pair, clears the serial comparator, streams both operands
// MSB-first into it and returns the captured flags over a result handshake.
module serial_compare_sequencer
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    serial_compare_sequencer_if.slave  bus,
    output logic                       cmp_a,
    output logic                       cmp_b,
    output logic                       cmp_clear,
    input  logic                       cmp_g,
    input  logic                       cmp_e,
    input  logic                       cmp_l
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_cmp_clear;
    logic             r_out_valid;
    logic             r_shift_en;
    logic [2:0]       r_res;
    logic             r_res_err;

    logic             w_load;
    logic             w_a_msb;
    logic             w_b_msb;

    assign w_load = r_in_ready && bus.in_valid;

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (w_load),
        .shift   (r_shift_en),
        .par_in  (bus.op_a),
        .ser_out (w_a_msb)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (w_load),
        .shift   (r_shift_en),
        .par_in  (bus.op_b),
        .ser_out (w_b_msb)
    );

    // Handshake outputs are registered alongside the state, so nothing
    // combinational runs from in_valid/out_ready to an output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_cmp_clear <= 1'b1;
            r_out_valid <= 1'b0;
            r_shift_en  <= 1'b0;
            r_res       <= '0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state    <= CLEAR;
                        r_in_ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    r_cnt       <= '0;
                    r_state     <= SHIFT;
                    r_cmp_clear <= 1'b0;
                    r_shift_en  <= 1'b1;
                end
                SHIFT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state    <= CAPTURE;
                        r_shift_en <= 1'b0;
                    end
                end
                CAPTURE: begin
                    r_res       <= {cmp_g, cmp_e, cmp_l};
                    r_res_err   <= !is_one_hot3({cmp_g, cmp_e, cmp_l});
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_cmp_clear <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_cmp_clear <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_shift_en  <= 1'b0;
                end
            endcase
        end
    end

    // Serial bits are gated so the comparator only sees data while shifting.
    assign cmp_a     = r_shift_en && w_a_msb;
    assign cmp_b     = r_shift_en && w_b_msb;
    assign cmp_clear = r_cmp_clear;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.res_gt    = r_res[2];
    assign bus.res_eq    = r_res[1];
    assign bus.res_lt    = r_res[0];
    assign bus.res_err   = r_res_err;

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Directed bench: an 8-bit and a 1-bit sequencer, each driving a serial_comparator.
// Result flags are compared as {gt,eq,lt,err}.
module tb_serial_compare_sequencer;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic force_gl = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    serial_compare_sequencer_if #(.WIDTH(8)) bus8 ();
    serial_compare_sequencer_if #(.WIDTH(1)) bus1 ();

    logic cmp_a8, cmp_b8, clr8, g8, e8, l8;
    logic cmp_a1, cmp_b1, clr1, g1_raw, e1, l1_raw, g1, l1;

    assign g1 = force_gl ? 1'b1 : g1_raw;
    assign l1 = force_gl ? 1'b1 : l1_raw;

    serial_compare_sequencer #(.WIDTH(8)) dut8 (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus8),
        .cmp_a     (cmp_a8),
        .cmp_b     (cmp_b8),
        .cmp_clear (clr8),
        .cmp_g     (g8),
        .cmp_e     (e8),
        .cmp_l     (l8)
    );

    serial_comparator cmp8 (
        .clock (clock),
        .reset (clr8),
        .a     (cmp_a8),
        .b     (cmp_b8),
        .g     (g8),
        .e     (e8),
        .l     (l8)
    );

    serial_compare_sequencer #(.WIDTH(1)) dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus1),
        .cmp_a     (cmp_a1),
        .cmp_b     (cmp_b1),
        .cmp_clear (clr1),
        .cmp_g     (g1),
        .cmp_e     (e1),
        .cmp_l     (l1)
    );

    serial_comparator cmp1 (
        .clock (clock),
        .reset (clr1),
        .a     (cmp_a1),
        .b     (cmp_b1),
        .g     (g1_raw),
        .e     (e1),
        .l     (l1_raw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] res8();
        return {bus8.res_gt, bus8.res_eq, bus8.res_lt, bus8.res_err};
    endfunction

    function automatic logic [3:0] res1();
        return {bus1.res_gt, bus1.res_eq, bus1.res_lt, bus1.res_err};
    endfunction

    // lat counts edges from the accept edge (counted as 1) to out_valid seen high.
    task automatic transact8(input logic [7:0] a, input logic [7:0] b,
                             output int lat, output logic [7:0] seq, output logic [2:0] first);
        lat   = -1;
        seq   = '0;
        first = '0;
        @(negedge clock);
        bus8.in_valid = 1'b1;
        bus8.op_a     = a;
        bus8.op_b     = b;
        @(posedge clock);
        #1;
        bus8.in_valid = 1'b0;
        bus8.op_a     = ~a;
        bus8.op_b     = ~b;
        for (int n = 1; n <= 40; n++) begin
            if (n >= 2 && n <= 9) seq[9-n] = cmp_a8;
            if (n == 3) first = {g8, e8, l8};
            if (bus8.out_valid) begin
                lat = n;
                break;
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int         lat;
        logic [7:0] seq;
        logic [2:0] first;
        int         acc[2];
        int         na;
        logic       seen;

        bus8.in_valid = 1'b0; bus8.op_a = '0; bus8.op_b = '0; bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", bus8.in_ready, 1);
        check("rst_cmp_clear", clr8, 1);
        check("rst_out_valid", bus8.out_valid, 0);
        check("rst_cmp_ab", {cmp_a8, cmp_b8}, 0);
        check("rst_res", res8(), 4'b0000);
        check("rst_in_ready_w1", bus1.in_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;

        // A5 vs 5A: greater, decided on the first bit
        bus8.out_ready = 1'b1;
        transact8(8'hA5, 8'h5A, lat, seq, first);
        check("a5_latency", lat, 11);
        check("a5_cmp_a_seq", seq, 8'hA5);
        check("a5_first_flags", first, 3'b100);
        check("a5_res", res8(), 4'b1000);
        check("a5_in_ready_done", bus8.in_ready, 0);
        @(posedge clock); #1;
        check("a5_back_idle", bus8.in_ready, 1);

        // Equal operands
        transact8(8'h3C, 8'h3C, lat, seq, first);
        check("3c_latency", lat, 11);
        check("3c_first_flags", first, 3'b010);
        check("3c_res", res8(), 4'b0100);
        @(posedge clock); #1;

        // 00 vs FF: less, decided on the first bit
        transact8(8'h00, 8'hFF, lat, seq, first);
        check("00ff_latency", lat, 11);
        check("00ff_first_flags", first, 3'b001);
        check("00ff_res", res8(), 4'b0010);
        @(posedge clock); #1;

        // DONE held for 5 cycles with out_ready low; in_valid offered and ignored
        bus8.out_ready = 1'b0;
        transact8(8'h81, 8'h80, lat, seq, first);
        check("hold_latency", lat, 11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus8.in_valid = 1'b1;
            bus8.op_a     = 8'h00;
            bus8.op_b     = 8'hFF;
            @(posedge clock); #1;
            check("hold_out_valid", bus8.out_valid, 1);
            check("hold_in_ready", bus8.in_ready, 0);
            check("hold_res", res8(), 4'b1000);
            check("hold_cmp_a", cmp_a8, 0);
        end
        @(negedge clock);
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clock); #1;
        check("release_in_ready", bus8.in_ready, 1);
        check("release_out_valid", bus8.out_valid, 0);
        check("release_res_held", res8(), 4'b1000);

        // Back-to-back accepts with in_valid held high
        bus8.op_a     = 8'h10;
        bus8.op_b     = 8'h20;
        bus8.in_valid = 1'b1;
        na = 0;
        for (int i = 0; i < 40 && na < 2; i++) begin
            @(negedge clock);
            if (bus8.in_ready) begin
                acc[na] = i;
                na++;
            end
        end
        @(posedge clock); #1;
        bus8.in_valid = 1'b0;
        check("b2b_accepts", na, 2);
        if (na == 2) check("b2b_spacing", acc[1] - acc[0], 12);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus8.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        check("b2b_seen", seen, 1);
        check("b2b_res", res8(), 4'b0010);
        @(posedge clock); #1;

        // Asynchronous reset after 3 bits of SHIFT
        @(negedge clock);
        bus8.in_valid = 1'b1;
        bus8.op_a     = 8'hFF;
        bus8.op_b     = 8'h00;
        @(posedge clock); #1;
        bus8.in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("abort_in_ready", bus8.in_ready, 1);
        check("abort_out_valid", bus8.out_valid, 0);
        check("abort_cmp_clear", clr8, 1);
        check("abort_cmp_a", cmp_a8, 0);
        check("abort_res", res8(), 4'b0000);
        @(negedge clock);
        reset_n = 1'b1;
        transact8(8'h01, 8'h02, lat, seq, first);
        check("post_abort_latency", lat, 11);
        check("post_abort_first", first, 3'b010);
        check("post_abort_res", res8(), 4'b0010);
        @(posedge clock); #1;

        // WIDTH=1: 1 vs 0
        @(negedge clock);
        bus1.in_valid = 1'b1;
        bus1.op_a     = 1'b1;
        bus1.op_b     = 1'b0;
        @(posedge clock); #1;
        bus1.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            if (bus1.out_valid) begin
                lat = n;
                break;
            end
            @(posedge clock); #1;
        end
        check("w1_latency", lat, 4);
        check("w1_res", res1(), 4'b1000);
        @(posedge clock); #1;
        check("w1_back_idle", bus1.in_ready, 1);

        // WIDTH=1: g and l forced high during CAPTURE -> error flag
        @(negedge clock);
        bus1.in_valid = 1'b1;
        bus1.op_a     = 1'b1;
        bus1.op_b     = 1'b1;
        @(posedge clock); #1;
        bus1.in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        force_gl = 1'b1;
        @(posedge clock); #1;
        force_gl = 1'b0;
        check("w1_err_out_valid", bus1.out_valid, 1);
        check("w1_err_res", res1(), 4'b1111);
        @(posedge clock); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
